iq_dac_frontend: RTL and testbench

Parametrised I/Q-to-DAC output stage. Sits between the burst controller's two's-complement I/Q outputs and the two parallel DAC buses. Converts signed samples to offset-binary DAC codes, with selectable rounding and saturation. Applies a linear power ramp at burst start and end to limit splatter, and parks both DACs at midscale when idle.

---
 rtl/iq_dac_frontend_pkg.sv | 19 +
 rtl/iq_dac_frontend_format.sv | 45 ++++
 rtl/iq_dac_frontend.sv | 139 +++++++++++++
 tb/tb_iq_dac_frontend.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/iq_dac_frontend_pkg.sv
// Shared types and constants for the I/Q DAC output stage.
package iq_dac_frontend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    ACTIVE,
    RAMP_DOWN
  } ramp_state_t;

  localparam int MIN_DAC_WIDTH = 1;
  localparam int MIN_RAMP_LOG2 = 1;

  // Offset-binary code for a zero-amplitude sample.
  function automatic int midscale(input int dac_width);
    return 1 << (dac_width - 1);
  endfunction

endpackage

// File: rtl/iq_dac_frontend_format.sv
// Stage 2 for one channel: signed sample to offset-binary DAC code,
// optionally rounded half-up with saturation on carry-out.
module dac_code_format
  import iq_dac_frontend_pkg::*;
#(
  parameter int IN_WIDTH  = 9,
  parameter int DAC_WIDTH = 6,
  parameter int ROUND_EN  = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic signed [IN_WIDTH-1:0] sample,
  output logic [DAC_WIDTH-1:0]       code
);

  localparam logic [DAC_WIDTH-1:0] MID      = DAC_WIDTH'(midscale(DAC_WIDTH));
  localparam logic [IN_WIDTH-1:0]  SIGN_BIT = IN_WIDTH'(1) << (IN_WIDTH - 1);

  logic [IN_WIDTH-1:0]  offset;
  logic [DAC_WIDTH-1:0] code_next;

  assign offset = $unsigned(sample) ^ SIGN_BIT;

  generate
    if (ROUND_EN != 0 && IN_WIDTH > DAC_WIDTH) begin : g_round
      localparam int DROP = IN_WIDTH - DAC_WIDTH;
      localparam logic [IN_WIDTH:0] HALF = (IN_WIDTH + 1)'(1) << (DROP - 1);
      logic [IN_WIDTH:0] rounded;
      assign rounded   = {1'b0, offset} + HALF;
      // A carry out of the top bit means the positive rail was exceeded.
      assign code_next = rounded[IN_WIDTH] ? '1 : DAC_WIDTH'(rounded >> DROP);
    end else begin : g_trunc
      assign code_next = DAC_WIDTH'(offset >> (IN_WIDTH - DAC_WIDTH));
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      code <= MID;
    end else begin
      code <= code_next;
    end
  end

endmodule

// File: rtl/iq_dac_frontend.sv
// I/Q DAC front end: ramp FSM, gain scaling (stage 1) and per-channel
// code formatting (stage 2); parks at midscale while idle.
module iq_dac_frontend
  import iq_dac_frontend_pkg::*;
#(
  parameter int IN_WIDTH  = 9,
  parameter int DAC_WIDTH = 6,
  parameter int RAMP_LOG2 = 3,
  parameter int ROUND_EN  = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       iq_valid_i,
  input  logic signed [IN_WIDTH-1:0] inphase_i,
  input  logic signed [IN_WIDTH-1:0] quadrature_i,
  output logic [DAC_WIDTH-1:0]       dac_i_o,
  output logic [DAC_WIDTH-1:0]       dac_q_o,
  output logic                       txchain_en_o,
  output logic                       ramp_busy_o
);

  localparam int             GW     = RAMP_LOG2 + 1;
  localparam int             PW     = IN_WIDTH + RAMP_LOG2 + 2;
  localparam logic [GW-1:0]  G_FULL = GW'(1) << RAMP_LOG2;

  generate
    if (DAC_WIDTH < MIN_DAC_WIDTH || DAC_WIDTH > IN_WIDTH || RAMP_LOG2 < MIN_RAMP_LOG2) begin : g_bad_params
      $error("iq_dac_frontend: illegal width parameters");
    end
  endgenerate

  ramp_state_t             state_reg, state_next;
  logic [GW-1:0]           gain_reg, gain_next;
  logic signed [PW-1:0]    gain_ext;
  logic [1:0]              en_pipe_reg;
  logic                    en_now;
  logic signed [IN_WIDTH-1:0] live [2];
  logic [DAC_WIDTH-1:0]    code [2];

  always_comb begin
    state_next = state_reg;
    gain_next  = gain_reg;
    case (state_reg)
      IDLE: begin
        gain_next = '0;
        if (iq_valid_i) begin
          gain_next  = GW'(1);
          state_next = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (!iq_valid_i) begin
          state_next = RAMP_DOWN;
        end else begin
          gain_next = gain_reg + GW'(1);
          if (gain_next == G_FULL) state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        gain_next = G_FULL;
        if (!iq_valid_i) begin
          gain_next  = G_FULL - GW'(1);
          state_next = RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        if (iq_valid_i) begin
          state_next = RAMP_UP;
        end else begin
          gain_next = gain_reg - GW'(1);
          if (gain_next == '0) state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        gain_next  = '0;
      end
    endcase
  end

  // The first valid sample of a burst is scaled by zero yet still belongs to the burst.
  assign en_now   = (state_reg != IDLE) || iq_valid_i;
  assign gain_ext = PW'($signed({1'b0, gain_reg}));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      gain_reg    <= '0;
      en_pipe_reg <= '0;
    end else begin
      state_reg   <= state_next;
      gain_reg    <= gain_next;
      en_pipe_reg <= {en_pipe_reg[0], en_now};
    end
  end

  assign live[0] = inphase_i;
  assign live[1] = quadrature_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic signed [IN_WIDTH-1:0] held_reg;
      logic signed [IN_WIDTH-1:0] src;
      logic signed [IN_WIDTH-1:0] s1_reg;
      logic signed [PW-1:0]       prod;

      assign src  = iq_valid_i ? live[gi] : held_reg;
      assign prod = PW'(src) * gain_ext;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          held_reg <= '0;
          s1_reg   <= '0;
        end else begin
          if (iq_valid_i) held_reg <= live[gi];
          s1_reg <= IN_WIDTH'(prod >>> RAMP_LOG2);
        end
      end

      dac_code_format #(
        .IN_WIDTH (IN_WIDTH),
        .DAC_WIDTH(DAC_WIDTH),
        .ROUND_EN (ROUND_EN)
      ) u_fmt (
        .clock (clock),
        .reset (reset),
        .sample(s1_reg),
        .code  (code[gi])
      );
    end
  endgenerate

  assign dac_i_o      = code[0];
  assign dac_q_o      = code[1];
  assign txchain_en_o = en_pipe_reg[1];
  assign ramp_busy_o  = (state_reg == RAMP_UP) || (state_reg == RAMP_DOWN);

endmodule

// File: tb/tb_iq_dac_frontend.sv
// Scoreboard bench: three parameterisations, directed ramp/hold/reset vectors.
module tb_iq_dac_frontend;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: defaults (rounding), DUT B: truncation, DUT C: 12/12 bits, 2-cycle ramp.
  logic               ab_valid = 1'b0;
  logic signed [8:0]  ab_i = '0, ab_q = '0;
  logic [5:0]         a_dac_i, a_dac_q, b_dac_i, b_dac_q;
  logic               a_en, a_busy, b_en, b_busy;
  logic               c_valid = 1'b0;
  logic signed [11:0] c_i = '0, c_q = '0;
  logic [11:0]        c_dac_i, c_dac_q;
  logic               c_en, c_busy;

  iq_dac_frontend #(.IN_WIDTH(9), .DAC_WIDTH(6), .RAMP_LOG2(3), .ROUND_EN(1)) dut_a (
    .clock(clk), .reset(rst), .iq_valid_i(ab_valid), .inphase_i(ab_i), .quadrature_i(ab_q),
    .dac_i_o(a_dac_i), .dac_q_o(a_dac_q), .txchain_en_o(a_en), .ramp_busy_o(a_busy));

  iq_dac_frontend #(.IN_WIDTH(9), .DAC_WIDTH(6), .RAMP_LOG2(3), .ROUND_EN(0)) dut_b (
    .clock(clk), .reset(rst), .iq_valid_i(ab_valid), .inphase_i(ab_i), .quadrature_i(ab_q),
    .dac_i_o(b_dac_i), .dac_q_o(b_dac_q), .txchain_en_o(b_en), .ramp_busy_o(b_busy));

  iq_dac_frontend #(.IN_WIDTH(12), .DAC_WIDTH(12), .RAMP_LOG2(1), .ROUND_EN(1)) dut_c (
    .clock(clk), .reset(rst), .iq_valid_i(c_valid), .inphase_i(c_i), .quadrature_i(c_q),
    .dac_i_o(c_dac_i), .dac_q_o(c_dac_q), .txchain_en_o(c_en), .ramp_busy_o(c_busy));

  // Hand-computed codes indexed by the gain in force when the sample was taken.
  localparam int A_I_TAB [9] = '{32, 36, 40, 44, 48, 52, 56, 60, 63};
  localparam int B_I_TAB [9] = '{32, 35, 39, 43, 47, 51, 55, 59, 63};
  localparam int Q_TAB   [9] = '{32, 28, 24, 20, 16, 12, 8, 4, 0};
  localparam int C_I_TAB [3] = '{2048, 3071, 4095};
  localparam int C_Q_TAB [3] = '{2048, 1024, 0};

  typedef struct {
    int due;
    int dut;
    bit busy_chk;
    int di;
    int dq;
    bit en;
    bit busy;
  } exp_t;

  exp_t sb[$];
  int   ecount = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always @(posedge clk) ecount <= ecount + 1;

  function automatic string dut_name(input int d);
    return (d == 0) ? "A" : (d == 1) ? "B" : "C";
  endfunction

  function automatic void push(input int due, input int dut, input bit busy_chk,
                               input int di, input int dq, input bit en, input bit busy);
    exp_t e;
    e.due = due; e.dut = dut; e.busy_chk = busy_chk;
    e.di = di; e.dq = dq; e.en = en; e.busy = busy;
    sb.push_back(e);
  endfunction

  task automatic check_entry(input exp_t e);
    logic [11:0] ai, aq;
    logic        aen, abusy;
    case (e.dut)
      0:       begin ai = {6'b0, a_dac_i}; aq = {6'b0, a_dac_q}; aen = a_en; abusy = a_busy; end
      1:       begin ai = {6'b0, b_dac_i}; aq = {6'b0, b_dac_q}; aen = b_en; abusy = b_busy; end
      default: begin ai = c_dac_i; aq = c_dac_q; aen = c_en; abusy = c_busy; end
    endcase
    n_cmp++;
    if (e.busy_chk) begin
      if (abusy !== e.busy) begin
        n_bad++;
        $display("FAIL busy dut=%s cyc=%0d got=%0b want=%0b", dut_name(e.dut), ecount, abusy, e.busy);
      end else begin
        $display("ok   busy dut=%s cyc=%0d busy=%0b", dut_name(e.dut), ecount, abusy);
      end
    end else begin
      if (ai !== 12'(e.di) || aq !== 12'(e.dq) || aen !== e.en) begin
        n_bad++;
        $display("FAIL code dut=%s cyc=%0d got i=%0d q=%0d en=%0b want i=%0d q=%0d en=%0b",
                 dut_name(e.dut), ecount, ai, aq, aen, e.di, e.dq, e.en);
      end else begin
        $display("ok   code dut=%s cyc=%0d i=%0d q=%0d en=%0b", dut_name(e.dut), ecount, ai, aq, aen);
      end
    end
  endtask

  // Monitor: compares every expectation that falls due this cycle.
  always @(negedge clk) begin : monitor
    int k;
    k = 0;
    while (k < sb.size()) begin
      if (sb[k].due == ecount) begin
        check_entry(sb[k]);
        sb.delete(k);
      end else if (sb[k].due < ecount) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stale dut=%s due=%0d now=%0d", dut_name(sb[k].dut), sb[k].due, ecount);
        sb.delete(k);
      end else begin
        k++;
      end
    end
  end

  task automatic push_reset_state(input int due);
    for (int d = 0; d < 3; d++) begin
      int mid;
      mid = (d == 2) ? 2048 : 32;
      push(due, d, 1'b0, mid, mid, 1'b0, 1'b0);
      push(due, d, 1'b1, 0, 0, 1'b0, 1'b0);
    end
  endtask

  // One A/B cycle: g is the gain applied to this sample, en/busy the expected flags.
  task automatic row_ab(input bit v, input int g, input bit en, input bit busy);
    ab_valid = v;
    ab_i = v ? 9'h0FF : 9'h1B3;
    ab_q = v ? 9'h100 : 9'h063;
    push(ecount + 2, 0, 1'b0, A_I_TAB[g], Q_TAB[g], en, 1'b0);
    push(ecount + 2, 1, 1'b0, B_I_TAB[g], Q_TAB[g], en, 1'b0);
    push(ecount + 1, 0, 1'b1, 0, 0, 1'b0, busy);
    push(ecount + 1, 1, 1'b1, 0, 0, 1'b0, busy);
    @(posedge clk); #1;
  endtask

  task automatic row_c(input bit v, input int g, input bit en, input bit busy);
    c_valid = v;
    c_i = v ? 12'h7FF : 12'h123;
    c_q = v ? 12'h800 : 12'hE00;
    push(ecount + 2, 2, 1'b0, C_I_TAB[g], C_Q_TAB[g], en, 1'b0);
    push(ecount + 1, 2, 1'b1, 0, 0, 1'b0, busy);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", ecount);
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    push_reset_state(ecount);
    @(posedge clk); #2;
    rst = 1'b0;
    row_ab(0, 0, 0, 0);
    row_ab(0, 0, 0, 0);

    // Full burst up, hold in ACTIVE, full ramp down on the held sample.
    for (int g = 0; g <= 8; g++) row_ab(1, g, 1, g < 7);
    repeat (3) row_ab(1, 8, 1, 0);
    row_ab(0, 8, 1, 1);
    for (int g = 7; g >= 2; g--) row_ab(0, g, 1, 1);
    row_ab(0, 1, 1, 0);
    row_ab(0, 0, 0, 0);
    row_ab(0, 0, 0, 0);

    // Valid dropped at g=4 during ramp up.
    for (int g = 0; g <= 3; g++) row_ab(1, g, 1, 1);
    row_ab(0, 4, 1, 1);
    row_ab(0, 4, 1, 1);
    row_ab(0, 3, 1, 1);
    row_ab(0, 2, 1, 1);
    row_ab(0, 1, 1, 0);
    row_ab(0, 0, 0, 0);

    // Valid reasserted during ramp down at g=2.
    for (int g = 0; g <= 8; g++) row_ab(1, g, 1, g < 7);
    row_ab(0, 8, 1, 1);
    for (int g = 7; g >= 3; g--) row_ab(0, g, 1, 1);
    row_ab(1, 2, 1, 1);
    for (int g = 2; g <= 6; g++) row_ab(1, g, 1, 1);
    row_ab(1, 7, 1, 0);
    row_ab(1, 8, 1, 0);

    // Asynchronous reset in ACTIVE, checked before any further clock edge.
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    push_reset_state(ecount);
    @(posedge clk); #1;
    push_reset_state(ecount);
    #2;
    rst = 1'b0;
    ab_valid = 1'b0;
    row_ab(0, 0, 0, 0);
    row_ab(0, 0, 0, 0);

    // Full-width sweep: no rounding, 2-cycle ramps, rail codes.
    row_c(1, 0, 1, 1);
    row_c(1, 1, 1, 0);
    row_c(1, 2, 1, 0);
    row_c(1, 2, 1, 0);
    row_c(0, 2, 1, 1);
    row_c(0, 1, 1, 0);
    row_c(0, 0, 0, 0);
    row_c(0, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
